// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: compacting in-order instruction queue between fetch and decode.
// Rev 1.0 - initial release.
`default_nettype none

package fetch_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [5:0]  ftq_idx;
    logic        has_except;
  } fetchEntry_t;
endpackage

module fetch_inst_buffer #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [FETCH_WIDTH-1:0]                  i_fetch_vld,
  input  fetch_pkg::fetchEntry_t [FETCH_WIDTH-1:0] i_fetch_inst,
  output logic                                    o_fetch_rdy,
  input  logic                                    i_dec_rdy,
  output logic [DECODE_WIDTH-1:0]                 o_dec_vld,
  output fetch_pkg::fetchEntry_t [DECODE_WIDTH-1:0] o_dec_inst,
  input  logic                                    i_flush,
  output logic [$clog2(DEPTH):0]                  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_pkg::fetchEntry_t mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] enq_off [FETCH_WIDTH];
  logic [CNT_W-1:0] enq_acc, enq_num;
  logic [CNT_W-1:0] avail, deq_num;
  logic             group_stop;
  logic             enq_fire, deq_fire;
  logic [DECODE_WIDTH-1:0] vld_plus1;

  assign o_fetch_rdy = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign o_count     = count;
  assign enq_fire    = o_fetch_rdy & (|i_fetch_vld) & ~i_flush;
  assign deq_fire    = i_dec_rdy & (deq_num != '0) & ~i_flush;

  // Each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin
    enq_acc = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_off[i] = enq_acc[PTR_W-1:0];
      enq_acc    = enq_acc + CNT_W'(i_fetch_vld[i]);
    end
    enq_num = enq_acc;
  end

  // Group is the oldest entries, closed after the first excepting one.
  always_comb begin
    avail      = (count < CNT_W'(DECODE_WIDTH)) ? count : CNT_W'(DECODE_WIDTH);
    deq_num    = '0;
    group_stop = 1'b0;
    o_dec_vld  = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      o_dec_inst[k] = mem[head + PTR_W'(k)];
      if (!group_stop && (CNT_W'(k) < avail)) begin
        o_dec_vld[k] = 1'b1;
        deq_num      = deq_num + CNT_W'(1);
        group_stop   = o_dec_inst[k].has_except;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (i_fetch_vld[i]) mem[tail + enq_off[i]] <= i_fetch_inst[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + enq_num[PTR_W-1:0];
      if (deq_fire) head <= head + deq_num[PTR_W-1:0];
      count <= count + (enq_fire ? enq_num : '0) - (deq_fire ? deq_num : '0);
    end
  end

  assign vld_plus1 = o_dec_vld + DECODE_WIDTH'(1);

  a_count_max: assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(DEPTH));
  a_vld_contig: assert property (@(posedge clk) disable iff (!rst) (vld_plus1 & o_dec_vld) == '0);
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst) !(enq_fire && !o_fetch_rdy));

endmodule

`default_nettype wire

// File: tb/tb_fetch_inst_buffer.sv
// tb_fetch_inst_buffer: scoreboard plus vector table for the fetch instruction buffer.
`default_nettype none

module tb_fetch_inst_buffer;
  import fetch_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        i_fetch_vld = '0;
  fetchEntry_t [3:0] i_fetch_inst = '0;
  logic              o_fetch_rdy;
  logic              i_dec_rdy = 1'b0;
  logic [3:0]        o_dec_vld;
  fetchEntry_t [3:0] o_dec_inst;
  logic              i_flush = 1'b0;
  logic [4:0]        o_count;

  fetch_inst_buffer #(.FETCH_WIDTH(4), .DECODE_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .i_fetch_vld(i_fetch_vld), .i_fetch_inst(i_fetch_inst),
    .o_fetch_rdy(o_fetch_rdy), .i_dec_rdy(i_dec_rdy), .o_dec_vld(o_dec_vld),
    .o_dec_inst(o_dec_inst), .i_flush(i_flush), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  next_id = '0;
  fetchEntry_t sb [$];

  typedef struct {
    logic [3:0] fv;
    logic [3:0] ex;
    logic       dr;
    logic       fl;
    int         exp_cnt;
    logic [3:0] exp_vld;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_m();
    int n = (sb.size() < 4) ? sb.size() : 4;
    int m = 0;
    for (int k = 0; k < n; k++) begin
      m++;
      if (sb[k].has_except) break;
    end
    return m;
  endfunction

  // Drive one cycle, check pre-edge outputs against the model, then advance the model.
  task automatic step(input logic [3:0] fv, input logic [3:0] ex, input logic dr, input logic fl);
    fetchEntry_t ent [4];
    fetchEntry_t e;
    int   m;
    logic mrdy;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      ent[s].inst       = $urandom;
      ent[s].has_except = ex[s];
      if (fv[s]) begin
        ent[s].ftq_idx = next_id;
        next_id++;
      end else begin
        ent[s].ftq_idx = 6'h3f;
      end
      i_fetch_inst[s] = ent[s];
    end
    i_fetch_vld = fv;
    i_dec_rdy   = dr;
    i_flush     = fl;
    #1;
    mrdy = (sb.size() <= 12);
    m    = exp_m();
    chk("count", 64'(o_count), 64'(sb.size()));
    chk("fetch_rdy", 64'(o_fetch_rdy), 64'(mrdy));
    chk("dec_vld", 64'(o_dec_vld), 64'((1 << m) - 1));
    for (int k = 0; k < m; k++) begin
      if (dr && !fl) begin
        e = sb.pop_front();
        chk("dec_inst_pop", 64'(o_dec_inst[k]), 64'(e));
      end else begin
        chk("dec_inst_hold", 64'(o_dec_inst[k]), 64'(sb[k]));
      end
    end
    if (fl) sb.delete();
    else if (mrdy) begin
      for (int s = 0; s < 4; s++) if (fv[s]) sb.push_back(ent[s]);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b1010, 4'b0000, 1'b1, 1'b0,  2, 4'b0011};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0,  0, 4'b0000};
    tbl[2]  = '{4'b1111, 4'b0010, 1'b0, 1'b0,  4, 4'b0011};
    tbl[3]  = '{4'b0011, 4'b0000, 1'b0, 1'b0,  6, 4'b0011};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0,  4, 4'b1111};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0,  0, 4'b0000};
    tbl[6]  = '{4'b0111, 4'b0100, 1'b0, 1'b0,  3, 4'b0111};
    tbl[7]  = '{4'b1001, 4'b0001, 1'b1, 1'b0,  2, 4'b0001};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0,  1, 4'b0001};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0,  0, 4'b0000};
    tbl[10] = '{4'b1111, 4'b0000, 1'b0, 1'b0,  4, 4'b1111};
    tbl[11] = '{4'b0110, 4'b0000, 1'b1, 1'b1,  0, 4'b0000};

    #2 rst = 1'b0;
    #1;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_vld", 64'(o_dec_vld), 64'd0);
    chk("rst_rdy", 64'(o_fetch_rdy), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Compaction, exception grouping and a flush, with hand-computed post-edge values.
    for (int v = 0; v < 12; v++) begin
      step(tbl[v].fv, tbl[v].ex, tbl[v].dr, tbl[v].fl);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_count", v), 64'(o_count), 64'(tbl[v].exp_cnt));
      chk($sformatf("tbl%0d_vld", v), 64'(o_dec_vld), 64'(tbl[v].exp_vld));
    end

    // Fill to 16 with decode stalled, then drain.
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("full_count", 64'(o_count), 64'd16);
    chk("full_rdy", 64'(o_fetch_rdy), 64'd0);
    for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Steady state at count 10 with simultaneous enqueue/dequeue across pointer wrap.
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b0011, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b1111, 4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("steady_count", 64'(o_count), 64'd10);
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Flush at count 9 with a concurrent fetch group and decode accept.
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_vld", 64'(o_dec_vld), 64'd0);
    step(4'b0101, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Asynchronous reset with seven entries buffered.
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    step(4'b0111, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    i_fetch_vld = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 64'(o_count), 64'd0);
    chk("arst_vld", 64'(o_dec_vld), 64'd0);
    chk("arst_rdy", 64'(o_fetch_rdy), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    step(4'b0100, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rfv, rex;
      logic       rdr, rfl;
      rfv = 4'($urandom);
      rex = 4'($urandom & $urandom & $urandom);
      rdr = ($urandom_range(0, 3) != 0);
      rfl = ($urandom_range(0, 31) == 0);
      step(rfv, rex, rdr, rfl);
    end
    step(4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_inst_buffer.md
Name: fetch_inst_buffer

Overview:
In-order instruction buffer and dispatch scheduler between the fetch stage and ctrlBlock's decode input. It accepts up to FETCH_WIDTH fetchEntry_t per cycle with an arbitrary valid mask, compacts them in slot order into a circular queue, and presents up to DECODE_WIDTH oldest entries to ctrlBlock as a contiguous i_inst_vld/i_inst group. It applies backpressure, handles pipeline flush, and serialises excepting entries so that an entry with has_except=1 always closes its dispatch group.

Parameters:
FETCH_WIDTH, 4, fetch slots per cycle
DECODE_WIDTH, 4, decode slots per cycle (matches ctrlBlock WIDTH)
DEPTH, 16, queue entries; power of two, >= FETCH_WIDTH+DECODE_WIDTH

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
i_fetch_vld  input  FETCH_WIDTH  per-slot valid; any bit pattern legal
i_fetch_inst  input  FETCH_WIDTH x fetchEntry_t  fetched entries, slot 0 oldest
o_fetch_rdy  output  1  buffer can take a full fetch group this cycle
i_dec_rdy  input  1  decode accepts the whole presented group this cycle
o_dec_vld  output  DECODE_WIDTH  dispatch valid, contiguous from bit 0
o_dec_inst  output  DECODE_WIDTH x fetchEntry_t  dispatched entries, slot 0 oldest
i_flush  input  1  discard all buffered and incoming entries
o_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, async): head=0, tail=0, count=0. Outputs: o_dec_vld=0, o_count=0, o_fetch_rdy=1. Storage contents are don't-care.
- o_fetch_rdy = (count <= DEPTH-FETCH_WIDTH), computed combinationally from registered count. It does not depend on same-cycle dequeue.
- Enqueue fires when o_fetch_rdy & |i_fetch_vld & !i_flush.
  - Valid slots are written in ascending slot order at tail, tail+1, ... (compacted; gaps are removed).
  - tail += popcount(i_fetch_vld), modulo DEPTH.
- Presented group:
  - n = min(count, DECODE_WIDTH) oldest entries, starting at head.
  - The group is truncated after the first entry with has_except=1, counting from slot 0.
  - o_dec_vld[k]=1 for k < m, where m is the truncated size; o_dec_inst[k]=entry[head+k]. o_dec_inst slots with vld=0 are don't-care.
  - These outputs are combinational from the storage and pointers.
- Dequeue fires when i_dec_rdy & (m>0) & !i_flush: head += m and count -= m. There is no partial acceptance.
- Count update: count_next = count + enq_num - deq_num. Simultaneous enqueue and dequeue are both applied.
- Latency: an entry enqueued in cycle t is presentable in cycle t+1. There is no fetch-to-decode bypass, even when the buffer is empty.
- Flush: i_flush=1 sets head=tail=0 and count=0 at the next edge.
  - The fetch input in that cycle is dropped and no dequeue is counted.
  - Flush has priority over all other events.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Group read indices (head+k) wrap modulo DEPTH.
- Full: count > DEPTH-FETCH_WIDTH drops o_fetch_rdy, so overflow is impossible by construction. Fetch holding data while o_fetch_rdy=0 causes no state change.
- Empty: count=0 gives o_dec_vld=0; i_dec_rdy is ignored.
- Assertions:
  - count never exceeds DEPTH.
  - o_dec_vld is always of the form 2^m-1.
  - No enqueue occurs while o_fetch_rdy=0.

Test Plan:
1. Reset mid-traffic: with count=7, drop rst to 0 asynchronously -> o_dec_vld=0 and o_count=0 immediately; o_fetch_rdy=1; first enqueue after release lands at index 0.
2. Compaction: one cycle with i_fetch_vld=4'b1010, inst A in slot 1 and B in slot 3, i_dec_rdy=1 -> next cycle o_dec_vld=4'b0011 with slot0=A, slot1=B; following cycle o_count=0.
3. Backpressure/full: i_dec_rdy=0, enqueue 4 entries per cycle -> o_fetch_rdy falls after count reaches 16 (four cycles); further input is ignored; o_count holds at 16. Raise i_dec_rdy -> 4 entries leave per cycle in fetch order; o_fetch_rdy returns once count <= 12.
4. Exception serialisation: buffer holds E0..E5 with has_except=1 on E1 -> groups are {E0,E1} (vld=0011), then {E2,E3,E4,E5} (vld=1111).
5. Simultaneous events: count=10, enqueue 4 and dequeue 4 in the same cycle -> count stays 10; o_fetch_rdy stays 1. Repeat across 8+ cycles to force pointer wrap and confirm order via ftq_idx sequence 0,1,2,...
6. Flush: count=9 with concurrent valid fetch and i_dec_rdy=1, assert i_flush -> next cycle o_count=0 and o_dec_vld=0; neither the flushed fetch group nor the entries presented that cycle appear later.
